// File: rtl/punc_control_pkg.sv
// Shared encodings for the PUnC LC3 control unit: opcodes, FSM states,
// datapath mux selects and the bundled control word.
package punc_control_pkg;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_EXEC2  = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] PC_SEL_OFF9   = 2'd0;
    localparam logic [1:0] PC_SEL_OFF11  = 2'd1;
    localparam logic [1:0] PC_SEL_REG    = 2'd2;

    localparam logic [1:0] MEM_R_PC      = 2'd0;
    localparam logic [1:0] MEM_R_OFF9    = 2'd1;
    localparam logic [1:0] MEM_R_R0      = 2'd2;
    localparam logic [1:0] MEM_R_BASE6   = 2'd3;

    localparam logic [1:0] MEM_W_OFF9    = 2'd0;
    localparam logic [1:0] MEM_W_PREV    = 2'd1;
    localparam logic [1:0] MEM_W_BASE6   = 2'd2;

    localparam logic [1:0] RF_W_ALU      = 2'd0;
    localparam logic [1:0] RF_W_OFF9     = 2'd1;
    localparam logic [1:0] RF_W_MEM      = 2'd2;
    localparam logic [1:0] RF_W_PC       = 2'd3;

    localparam logic       RF_WA_R7      = 1'b0;
    localparam logic       RF_WA_DR      = 1'b1;
    localparam logic       RF_R0_DR      = 1'b0;
    localparam logic       RF_R0_SR2     = 1'b1;

    localparam logic [1:0] ALU_PASSA     = 2'd0;
    localparam logic [1:0] ALU_ADD       = 2'd1;
    localparam logic [1:0] ALU_AND       = 2'd2;
    localparam logic [1:0] ALU_NOT       = 2'd3;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       mem_rd;
        logic       mem_wr;
        logic [1:0] mem_r_addr_sel;
        logic [1:0] mem_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       rf_w_wr;
        logic       rf_r0_addr_sel;
        logic       rf_r0_rd;
        logic       rf_r1_rd;
        logic       prev_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_first_val_sel;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/punc_control_if.sv
// Controller <-> datapath bundle: IR/condition status in, every control line out.
interface punc_control_if;
    logic [15:0] ir;
    logic        nzp_true;
    logic        pc_ld, pc_clr, pc_inc;
    logic [1:0]  pc_sel;
    logic        ir_ld, ir_clr;
    logic        mem_rd, mem_wr;
    logic [1:0]  mem_r_addr_sel, mem_w_addr_sel;
    logic [1:0]  rf_w_data_sel;
    logic        rf_w_addr_sel, rf_w_wr;
    logic        rf_r0_addr_sel, rf_r0_rd, rf_r1_rd;
    logic        prev_ld;
    logic        nzp_ld, nzp_clr;
    logic [1:0]  alu_sel;
    logic        alu_first_val_sel;
    logic        halted;

    modport master (
        input  ir, nzp_true,
        output pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, mem_rd, mem_wr,
               mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel,
               rf_w_wr, rf_r0_addr_sel, rf_r0_rd, rf_r1_rd, prev_ld, nzp_ld,
               nzp_clr, alu_sel, alu_first_val_sel, halted
    );

    modport slave (
        output ir, nzp_true,
        input  pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, mem_rd, mem_wr,
               mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel,
               rf_w_wr, rf_r0_addr_sel, rf_r0_rd, rf_r1_rd, prev_ld, nzp_ld,
               nzp_clr, alu_sel, alu_first_val_sel, halted
    );
endinterface

// File: rtl/punc_control.sv
// Multicycle LC3 control FSM: fetch, decode, execute (plus a second execute
// cycle for the indirect LDI/STI), with a terminal HALT.
module punc_control
    import punc_control_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    punc_control_if.master bus
);

    state_t     state, next_state, cur;
    ctrl_t      c;
    logic [3:0] op;

    assign op = bus.ir[15:12];
    // Reset shows INIT outputs immediately so the datapath clears act during reset.
    assign cur = rst ? S_INIT : state;

    always_ff @(posedge clk) begin
        if (rst) state <= S_INIT;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_INIT:   next_state = S_FETCH;
            S_FETCH:  next_state = S_DECODE;
            S_DECODE: next_state = (op == OP_TRAP) ? S_HALT : S_EXEC;
            S_EXEC:   next_state = (op == OP_LDI || op == OP_STI) ? S_EXEC2 : S_FETCH;
            S_EXEC2:  next_state = S_FETCH;
            S_HALT:   next_state = S_HALT;
            default:  next_state = S_INIT;
        endcase
    end

    always_comb begin
        c = '0;
        case (cur)
            S_INIT: begin
                c.pc_clr  = 1'b1;
                c.ir_clr  = 1'b1;
                c.nzp_clr = 1'b1;
            end
            S_FETCH: begin
                c.mem_rd         = 1'b1;
                c.mem_r_addr_sel = MEM_R_PC;
                c.ir_ld          = 1'b1;
                c.pc_inc         = 1'b1;
            end
            S_EXEC: begin
                case (op)
                    OP_ADD, OP_AND: begin
                        c.alu_sel           = (op == OP_ADD) ? ALU_ADD : ALU_AND;
                        c.alu_first_val_sel = bus.ir[5];
                        c.rf_r0_addr_sel    = RF_R0_SR2;
                        c.rf_r0_rd          = ~bus.ir[5];
                        c.rf_r1_rd          = 1'b1;
                        c.rf_w_data_sel     = RF_W_ALU;
                        c.rf_w_addr_sel     = RF_WA_DR;
                        c.rf_w_wr           = 1'b1;
                        c.nzp_ld            = 1'b1;
                    end
                    OP_NOT: begin
                        c.alu_sel       = ALU_NOT;
                        c.rf_r1_rd      = 1'b1;
                        c.rf_w_data_sel = RF_W_ALU;
                        c.rf_w_addr_sel = RF_WA_DR;
                        c.rf_w_wr       = 1'b1;
                        c.nzp_ld        = 1'b1;
                    end
                    OP_BR: begin
                        c.pc_ld  = bus.nzp_true;
                        c.pc_sel = PC_SEL_OFF9;
                    end
                    OP_JMP: begin
                        c.pc_ld    = 1'b1;
                        c.pc_sel   = PC_SEL_REG;
                        c.rf_r1_rd = 1'b1;
                    end
                    OP_JSR: begin
                        // R7 write and PC load share an edge, so JSRR R7 uses the old R7.
                        c.rf_w_data_sel = RF_W_PC;
                        c.rf_w_addr_sel = RF_WA_R7;
                        c.rf_w_wr       = 1'b1;
                        c.pc_ld         = 1'b1;
                        c.pc_sel        = bus.ir[11] ? PC_SEL_OFF11 : PC_SEL_REG;
                        c.rf_r1_rd      = ~bus.ir[11];
                    end
                    OP_LD, OP_LDR: begin
                        c.mem_rd         = 1'b1;
                        c.mem_r_addr_sel = (op == OP_LD) ? MEM_R_OFF9 : MEM_R_BASE6;
                        c.rf_r1_rd       = (op == OP_LDR);
                        c.rf_w_data_sel  = RF_W_MEM;
                        c.rf_w_addr_sel  = RF_WA_DR;
                        c.rf_w_wr        = 1'b1;
                        c.nzp_ld         = 1'b1;
                    end
                    OP_LEA: begin
                        c.rf_w_data_sel = RF_W_OFF9;
                        c.rf_w_addr_sel = RF_WA_DR;
                        c.rf_w_wr       = 1'b1;
                        c.nzp_ld        = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        c.mem_wr         = 1'b1;
                        c.mem_w_addr_sel = (op == OP_ST) ? MEM_W_OFF9 : MEM_W_BASE6;
                        c.rf_r0_addr_sel = RF_R0_DR;
                        c.rf_r0_rd       = 1'b1;
                        c.rf_r1_rd       = (op == OP_STR);
                    end
                    OP_LDI: begin
                        // Park the pointer in DR; EXEC2 reads through it on the R0 port.
                        c.mem_rd         = 1'b1;
                        c.mem_r_addr_sel = MEM_R_OFF9;
                        c.rf_w_data_sel  = RF_W_MEM;
                        c.rf_w_addr_sel  = RF_WA_DR;
                        c.rf_w_wr        = 1'b1;
                    end
                    OP_STI: begin
                        c.mem_rd         = 1'b1;
                        c.mem_r_addr_sel = MEM_R_OFF9;
                        c.prev_ld        = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                if (op == OP_LDI) begin
                    c.mem_rd         = 1'b1;
                    c.mem_r_addr_sel = MEM_R_R0;
                    c.rf_r0_addr_sel = RF_R0_DR;
                    c.rf_r0_rd       = 1'b1;
                    c.rf_w_data_sel  = RF_W_MEM;
                    c.rf_w_addr_sel  = RF_WA_DR;
                    c.rf_w_wr        = 1'b1;
                    c.nzp_ld         = 1'b1;
                end else if (op == OP_STI) begin
                    c.mem_wr         = 1'b1;
                    c.mem_w_addr_sel = MEM_W_PREV;
                    c.rf_r0_addr_sel = RF_R0_DR;
                    c.rf_r0_rd       = 1'b1;
                end
            end
            S_HALT:  c.halted = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_ld             = c.pc_ld;
    assign bus.pc_clr            = c.pc_clr;
    assign bus.pc_inc            = c.pc_inc;
    assign bus.pc_sel            = c.pc_sel;
    assign bus.ir_ld             = c.ir_ld;
    assign bus.ir_clr            = c.ir_clr;
    assign bus.mem_rd            = c.mem_rd;
    assign bus.mem_wr            = c.mem_wr;
    assign bus.mem_r_addr_sel    = c.mem_r_addr_sel;
    assign bus.mem_w_addr_sel    = c.mem_w_addr_sel;
    assign bus.rf_w_data_sel     = c.rf_w_data_sel;
    assign bus.rf_w_addr_sel     = c.rf_w_addr_sel;
    assign bus.rf_w_wr           = c.rf_w_wr;
    assign bus.rf_r0_addr_sel    = c.rf_r0_addr_sel;
    assign bus.rf_r0_rd          = c.rf_r0_rd;
    assign bus.rf_r1_rd          = c.rf_r1_rd;
    assign bus.prev_ld           = c.prev_ld;
    assign bus.nzp_ld            = c.nzp_ld;
    assign bus.nzp_clr           = c.nzp_clr;
    assign bus.alu_sel           = c.alu_sel;
    assign bus.alu_first_val_sel = c.alu_first_val_sel;
    assign bus.halted            = c.halted;

    // Operand/offset fields of IR are consumed by the datapath, not here.
    logic unused_ir;
    assign unused_ir = &{1'b0, bus.ir[10:6], bus.ir[4:0]};

endmodule

// File: tb/tb_punc_control.sv
// Directed bench for punc_control: walks the FSM through representative
// opcodes, checking the decoded control word state by state.
module tb_punc_control;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    punc_control_if bus ();

    punc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Every output except halted, packed for "all quiet" checks.
    logic [25:0] others;
    assign others = {bus.pc_ld, bus.pc_clr, bus.pc_inc, bus.pc_sel, bus.ir_ld,
                     bus.ir_clr, bus.mem_rd, bus.mem_wr, bus.mem_r_addr_sel,
                     bus.mem_w_addr_sel, bus.rf_w_data_sel, bus.rf_w_addr_sel,
                     bus.rf_w_wr, bus.rf_r0_addr_sel, bus.rf_r0_rd, bus.rf_r1_rd,
                     bus.prev_ld, bus.nzp_ld, bus.nzp_clr, bus.alu_sel,
                     bus.alu_first_val_sel};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expects to be called in FETCH; leaves the FSM in EXEC.
    task automatic to_exec(input logic [15:0] instr, input logic nzp);
        chk("fetch_ir_ld", 32'(bus.ir_ld), 32'd1);
        bus.ir       = instr;
        bus.nzp_true = nzp;
        tick();
        chk("decode_quiet", 32'(others), 32'd0);
        tick();
    endtask

    initial begin
        rst          = 1'b1;
        bus.ir       = 16'h0000;
        bus.nzp_true = 1'b0;

        // Reset held two cycles
        tick();
        chk("rst_pc_clr", 32'(bus.pc_clr), 32'd1);
        chk("rst_ir_clr", 32'(bus.ir_clr), 32'd1);
        chk("rst_nzp_clr", 32'(bus.nzp_clr), 32'd1);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("init_pc_clr", 32'(bus.pc_clr), 32'd1);
        chk("init_ir_ld", 32'(bus.ir_ld), 32'd0);
        tick();
        chk("fetch_pc_inc", 32'(bus.pc_inc), 32'd1);
        chk("fetch_mem_rd", 32'(bus.mem_rd), 32'd1);
        chk("fetch_raddr", 32'(bus.mem_r_addr_sel), 32'd0);
        chk("fetch_no_clr", 32'(bus.pc_clr), 32'd0);

        // ADD R1,R1,#1
        to_exec(16'h1261, 1'b0);
        chk("add_alu_sel", 32'(bus.alu_sel), 32'd1);
        chk("add_first_sel", 32'(bus.alu_first_val_sel), 32'd1);
        chk("add_wr", 32'(bus.rf_w_wr), 32'd1);
        chk("add_waddr", 32'(bus.rf_w_addr_sel), 32'd1);
        chk("add_wdata", 32'(bus.rf_w_data_sel), 32'd0);
        chk("add_nzp_ld", 32'(bus.nzp_ld), 32'd1);
        chk("add_r0_sel", 32'(bus.rf_r0_addr_sel), 32'd1);
        tick();

        // AND register form
        to_exec(16'h5283, 1'b0);
        chk("and_alu_sel", 32'(bus.alu_sel), 32'd2);
        chk("and_first_sel", 32'(bus.alu_first_val_sel), 32'd0);
        chk("and_r0_rd", 32'(bus.rf_r0_rd), 32'd1);
        tick();

        // BRnzp +5, not taken then taken
        to_exec(16'h0E05, 1'b0);
        chk("br_nt_pc_ld", 32'(bus.pc_ld), 32'd0);
        tick();
        to_exec(16'h0E05, 1'b1);
        chk("br_t_pc_ld", 32'(bus.pc_ld), 32'd1);
        chk("br_t_pc_sel", 32'(bus.pc_sel), 32'd0);
        tick();

        // NOT R1,R1
        to_exec(16'h927F, 1'b0);
        chk("not_alu_sel", 32'(bus.alu_sel), 32'd3);
        chk("not_wr", 32'(bus.rf_w_wr), 32'd1);
        chk("not_nzp_ld", 32'(bus.nzp_ld), 32'd1);
        tick();

        // ST R2,#1
        to_exec(16'h3401, 1'b0);
        chk("st_mem_wr", 32'(bus.mem_wr), 32'd1);
        chk("st_waddr", 32'(bus.mem_w_addr_sel), 32'd0);
        chk("st_rf_wr", 32'(bus.rf_w_wr), 32'd0);
        tick();

        // LDI R2,#2: four cycles
        to_exec(16'hA402, 1'b0);
        chk("ldi_e_raddr", 32'(bus.mem_r_addr_sel), 32'd1);
        chk("ldi_e_wdata", 32'(bus.rf_w_data_sel), 32'd2);
        chk("ldi_e_nzp_ld", 32'(bus.nzp_ld), 32'd0);
        chk("ldi_e_wr", 32'(bus.rf_w_wr), 32'd1);
        tick();
        chk("ldi_e2_raddr", 32'(bus.mem_r_addr_sel), 32'd2);
        chk("ldi_e2_r0_sel", 32'(bus.rf_r0_addr_sel), 32'd0);
        chk("ldi_e2_nzp_ld", 32'(bus.nzp_ld), 32'd1);
        chk("ldi_e2_mem_rd", 32'(bus.mem_rd), 32'd1);
        tick();

        // STI R3,#2
        to_exec(16'hB602, 1'b0);
        chk("sti_e_prev_ld", 32'(bus.prev_ld), 32'd1);
        chk("sti_e_mem_wr", 32'(bus.mem_wr), 32'd0);
        tick();
        chk("sti_e2_mem_wr", 32'(bus.mem_wr), 32'd1);
        chk("sti_e2_waddr", 32'(bus.mem_w_addr_sel), 32'd1);
        chk("sti_e2_prev_ld", 32'(bus.prev_ld), 32'd0);
        tick();

        // JSRR R7, then JSR +0
        to_exec(16'h41C0, 1'b0);
        chk("jsrr_waddr", 32'(bus.rf_w_addr_sel), 32'd0);
        chk("jsrr_wdata", 32'(bus.rf_w_data_sel), 32'd3);
        chk("jsrr_pc_sel", 32'(bus.pc_sel), 32'd2);
        chk("jsrr_pc_ld", 32'(bus.pc_ld), 32'd1);
        chk("jsrr_wr", 32'(bus.rf_w_wr), 32'd1);
        tick();
        to_exec(16'h4800, 1'b0);
        chk("jsr_pc_sel", 32'(bus.pc_sel), 32'd1);
        tick();

        // Reset mid-EXEC2
        to_exec(16'hA402, 1'b0);
        tick();
        chk("e2_before_rst", 32'(bus.nzp_ld), 32'd1);
        rst = 1'b1;
        #1;
        chk("e2_rst_clr", 32'(bus.pc_clr), 32'd1);
        chk("e2_rst_no_wr", 32'(bus.rf_w_wr), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("e2_rst_init", 32'(bus.ir_clr), 32'd1);
        tick();

        // TRAP/HALT: terminal until reset
        chk("halt_fetch", 32'(bus.ir_ld), 32'd1);
        bus.ir = 16'hF025;
        tick();
        chk("halt_decode", 32'(bus.halted), 32'd0);
        tick();
        for (int i = 0; i < 12; i++) begin
            chk("halt_halted", 32'(bus.halted), 32'd1);
            chk("halt_quiet", 32'(others), 32'd0);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("post_halt_init", 32'(bus.pc_clr), 32'd1);
        chk("post_halt_clear", 32'(bus.halted), 32'd0);
        tick();
        chk("post_halt_fetch", 32'(bus.ir_ld), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
